// File: rtl/essential_bit_serializer_pkg.sv
// ============================================================================
//  Module   : bitsparse_pkg
//  Purpose  : Shared types and helpers for the essential bit serializer.
//             - state_e          : serializer FSM states (IDLE, EMIT)
//             - idx_w()          : width of a bit-position index for a word
//             - onehot_is_single : true when a word has exactly one set bit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitsparse_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Widest operand the single-bit test supports; callers zero-extend.
  localparam int MAX_W = 64;

  function automatic int idx_w(input int bitsize);
    return $clog2(bitsize);
  endfunction

  // x & (x-1) drops the lowest set bit; a non-zero word that becomes zero
  // had exactly one bit set.
  function automatic logic onehot_is_single(input logic [MAX_W-1:0] word);
    logic [MAX_W-1:0] one;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    return (word != '0) && ((word & (word - one)) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/essential_bit_serializer_if.sv
// ============================================================================
//  Module   : essential_bit_serializer_if
//  Purpose  : Valid/ready bundle between weight buffer, serializer and PE.
//  Ports    : in_valid/in_ready/in_data  - operand word handshake
//             out_valid/out_ready        - term handshake
//             out_pos/out_last/out_zero  - term payload
//  Modports : master (producer/consumer side), slave (serializer side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface essential_bit_serializer_if
  import bitsparse_pkg::*;
#(
  parameter int bitsize = 8
);
  localparam int IDX_W = idx_w(bitsize);

  logic               in_valid;
  logic               in_ready;
  logic [bitsize-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_pos;
  logic               out_last;
  logic               out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_pos, out_last, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_pos, out_last, out_zero
  );

endinterface

`default_nettype wire

// File: rtl/essential_bit_serializer_bit_priority_encoder.sv
// ============================================================================
//  Module   : bit_priority_encoder
//  Purpose  : Combinational priority encoder. Returns the index of the lowest
//             (MSB_FIRST=0) or highest (MSB_FIRST=1) set bit of word.
//  Ports    : word  - input word
//             pos   - index of the selected set bit (0 when word is zero)
//             found - word has at least one set bit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_priority_encoder #(
  parameter int bitsize   = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [bitsize-1:0]         word,
  output logic [$clog2(bitsize)-1:0] pos,
  output logic                       found
);

  localparam int IDX_W = $clog2(bitsize);

  assign found = |word;

  // The last match in loop order wins, so the scan direction sets priority.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        pos = '0;
        for (int i = 0; i < bitsize; i++) begin
          if (word[i]) pos = IDX_W'(i);
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        pos = '0;
        for (int i = bitsize - 1; i >= 0; i--) begin
          if (word[i]) pos = IDX_W'(i);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/essential_bit_serializer.sv
// ============================================================================
//  Module   : essential_bit_serializer
//  Purpose  : Decomposes an operand word into its non-zero bit positions,
//             one position per beat, so the PE issues only useful shift-add
//             terms. An all-zero word yields one beat flagged out_zero.
//  Ports    : clk, rst (sync, active-high)
//             bus (slave) - in_valid/in_ready/in_data,
//                           out_valid/out_ready/out_pos/out_last/out_zero
//  Config   : ESSENTIAL_MSB_FIRST_EN - emit highest set bit first
//             (default: lowest set bit first)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module essential_bit_serializer
  import bitsparse_pkg::*;
#(
  parameter int bitsize = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  essential_bit_serializer_if.slave  bus
);

  localparam int IDX_W = idx_w(bitsize);

`ifdef ESSENTIAL_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [bitsize-1:0] residue_q, residue_d;
  logic               zero_flag_q, zero_flag_d;

  logic [IDX_W-1:0]   enc_pos;
  logic               enc_found;
  logic [bitsize-1:0] emit_mask;
  logic               single_bit;
  logic               last_handshake;

  bit_priority_encoder #(
    .bitsize   (bitsize),
    .MSB_FIRST (MSB_FIRST)
  ) u_enc (
    .word  (residue_q),
    .pos   (enc_pos),
    .found (enc_found)
  );

  assign single_bit = onehot_is_single(MAX_W'(residue_q));
  assign emit_mask  = enc_found ? (bitsize'(1) << enc_pos) : '0;

  // Outputs depend only on registered state; in_ready additionally opens on
  // the last-beat handshake so the next word follows without a bubble.
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_pos   = zero_flag_q ? '0 : enc_pos;
  assign bus.out_last  = zero_flag_q | single_bit;
  assign bus.out_zero  = zero_flag_q;

  assign last_handshake = bus.out_valid & bus.out_ready & bus.out_last;
  assign bus.in_ready   = (state_q == IDLE) | last_handshake;

  always_comb begin
    state_d     = state_q;
    residue_d   = residue_q;
    zero_flag_d = zero_flag_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          residue_d   = bus.in_data;
          zero_flag_d = (bus.in_data == '0);
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (bus.out_last) begin
            if (bus.in_valid) begin
              residue_d   = bus.in_data;
              zero_flag_d = (bus.in_data == '0);
            end else begin
              // Clearing here keeps the idle outputs at their reset values.
              residue_d   = '0;
              zero_flag_d = 1'b0;
              state_d     = IDLE;
            end
          end else begin
            residue_d = residue_q & ~emit_mask;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      residue_q   <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      residue_q   <= residue_d;
      zero_flag_q <= zero_flag_d;
    end
  end

endmodule

`default_nettype wire
